bus_arbiter: RTL and testbench
==============================

// Module: bus_arbiter
//
// PURPOSE
//  Round-robin arbiter granting the shared system bus to one of four bus masters.
//  Sits ahead of the bus master mux and slave mux; its one-hot grant selects which
//  master drives address/control, and s_ready from the slave mux marks transfer ends.
//  Bounds bus tenure: an owner that exceeds MAX_HOLD cycles is preempted at the next
//  completed transfer, but only when another master is waiting.
//
// PARAMETERS
//  MAX_HOLD   16  max owner tenure in cycles before preemption is allowed; 0 disables
//  CNT_W      5   hold-counter width; must satisfy 2**CNT_W > MAX_HOLD
//
// PORTS
//  clk        in   1    system clock, all logic on rising edge
//  reset      in   1    synchronous reset, active-high
//  m0_req     in   1    master 0 bus request (`YES = request)
//  m1_req     in   1    master 1 bus request
//  m2_req     in   1    master 2 bus request
//  m3_req     in   1    master 3 bus request
//  s_ready    in   1    current transfer complete (from slave mux)
//  m0_grnt    out  1    master 0 bus grant (registered)
//  m1_grnt    out  1    master 1 bus grant
//  m2_grnt    out  1    master 2 bus grant
//  m3_grnt    out  1    master 3 bus grant
//  owner      out  2    index of granted master; valid while bus_busy
//  bus_busy   out  1    `YES while any grant is asserted
//
// BEHAVIOUR
//  - Reset: all mN_grnt = `NO, owner = 0, bus_busy = `NO, state = IDLE,
//    priority pointer ptr = 0, hold counter cnt = 0. Reset mid-tenure drops grant next edge.
//  - Grants are registered; m*_grnt is one-hot or all-zero in every cycle.
//  - Priority search: starting at ptr, check ptr, ptr+1, ptr+2, ptr+3 (mod 4); the
//    first requester found wins.
//  - IDLE: if any req sampled at edge N, the winner's grnt is `YES from edge N+1;
//    owner = winner, cnt = 0, go OWN. No req: stay IDLE.
//  - OWN, owner req still `YES, no preemption: hold grant; cnt increments and
//    saturates at MAX_HOLD.
//  - OWN, owner req `NO (release): ptr = owner+1; search the other three masters in the
//    same cycle; if one is found, grant moves directly next edge with no idle gap,
//    cnt = 0; else all grants `NO next edge and state returns to IDLE.
//  - Preemption: applies when MAX_HOLD != 0, cnt >= MAX_HOLD, owner req `YES, at least
//    one other req `YES, and s_ready == `YES. Next edge the grant moves to the next
//    requester after owner, ptr = owner+1, cnt = 0. With s_ready `NO, the owner keeps
//    the bus until a transfer completes.
//  - Preempted master loses the bus only; its req stays pending and it re-enters
//    round-robin normally.
//  - Release and preemption in the same cycle: treated as release.
//  - New reqs arriving while OWN never disturb the owner except via preemption.
//  - bus_busy == |{m3_grnt..m0_grnt}; owner holds its last value in IDLE.
//
// TESTING
//  1 reset, m2_req=1 at cycle 3 -> m2_grnt=1 from cycle 4, owner=2, others 0.
//  2 m0 owns; m1,m3 req; m0 drops -> m1_grnt next cycle with no gap; m1 drops -> m3.
//  3 all four req, each drops after 2 cycles -> grant order 0,1,2,3,0 (round-robin).
//  4 MAX_HOLD=4, m0 holds, m2 req, s_ready=0 for cycles 4-7 then 1 -> no switch
//    until s_ready=1; m2_grnt next cycle; m0_grnt=0.
//  5 m1 alone, holds 40 cycles, s_ready=1 -> never preempted; cnt saturates.
//  6 reset asserted while m3 owns -> all grnt 0 next edge; ptr=0; m1,m3 req -> m1 wins.

Source files
------------

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for four bus masters with registered one-hot grants.
// An owner that has held the bus for MAX_HOLD cycles can be preempted at a transfer end.
module bus_arbiter #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       m0_req,
  input  logic       m1_req,
  input  logic       m2_req,
  input  logic       m3_req,
  input  logic       s_ready,
  output logic       m0_grnt,
  output logic       m1_grnt,
  output logic       m2_grnt,
  output logic       m3_grnt,
  output logic [1:0] owner,
  output logic       bus_busy
);

  typedef enum logic {IDLE, OWN} state_t;

  localparam logic             PREEMPT_EN = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0] HOLD_MAX   = CNT_W'(MAX_HOLD);

  state_t           state_q, state_d;
  logic [3:0]       grnt_q, grnt_d;
  logic [1:0]       owner_q, owner_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [3:0] req;
  logic       any_hit, other_hit, preempt;
  logic [1:0] any_win, other_win;

  // Returns {hit, index} of the first requester at or after start, optionally skipping one master.
  function automatic logic [2:0] search(input logic [3:0] rq, input logic [1:0] start,
                                        input logic skip_en, input logic [1:0] skip);
    logic [1:0] idx;
    logic       hit;
    logic [1:0] sel;
    hit = 1'b0;
    sel = start;
    for (int k = 3; k >= 0; k--) begin
      idx = start + 2'(k);
      if (rq[idx] && !(skip_en && (idx == skip))) begin
        hit = 1'b1;
        sel = idx;
      end
    end
    return {hit, sel};
  endfunction

  assign req = {m3_req, m2_req, m1_req, m0_req};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grnt_q  <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grnt_q  <= grnt_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    {any_hit, any_win}     = search(req, ptr_q, 1'b0, owner_q);
    {other_hit, other_win} = search(req, owner_q + 2'd1, 1'b1, owner_q);
    preempt = PREEMPT_EN && (cnt_q >= HOLD_MAX) && other_hit && s_ready;
    case (state_q)
      IDLE: begin
        if (any_hit) begin
          state_d = OWN;
          owner_d = any_win;
          cnt_d   = '0;
        end
      end
      OWN: begin
        // Release wins over preemption; both hand over starting just after the owner.
        if (!req[owner_q]) begin
          ptr_d = owner_q + 2'd1;
          if (other_hit) begin
            owner_d = other_win;
            cnt_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end else if (preempt) begin
          ptr_d   = owner_q + 2'd1;
          owner_d = other_win;
          cnt_d   = '0;
        end else if (cnt_q < HOLD_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    grnt_d = (state_d == OWN) ? (4'b0001 << owner_d) : 4'b0000;
  end

  always_comb begin
    m0_grnt  = grnt_q[0];
    m1_grnt  = grnt_q[1];
    m2_grnt  = grnt_q[2];
    m3_grnt  = grnt_q[3];
    owner    = owner_q;
    bus_busy = |grnt_q;
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios plus randomized traffic against a
// cycle-level model of the arbitration rules.
module tb_bus_arbiter;

  localparam int MH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       m0_req, m1_req, m2_req, m3_req, s_ready;
  logic       m0_grnt, m1_grnt, m2_grnt, m3_grnt;
  logic [1:0] owner;
  logic       bus_busy;
  logic [3:0] dut_g;

  int tests = 0;
  int fails = 0;

  // Reference model state
  bit m_busy;
  int m_owner, m_ptr, m_cnt;

  bus_arbiter #(.MAX_HOLD(MH), .CNT_W(5)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m1_req(m1_req), .m2_req(m2_req), .m3_req(m3_req),
    .s_ready(s_ready),
    .m0_grnt(m0_grnt), .m1_grnt(m1_grnt), .m2_grnt(m2_grnt), .m3_grnt(m3_grnt),
    .owner(owner), .bus_busy(bus_busy)
  );

  always #5 clk = ~clk;
  assign dut_g = {m3_grnt, m2_grnt, m1_grnt, m0_grnt};

  function automatic int pick(input logic [3:0] rq, input int start, input int skip);
    for (int k = 0; k < 4; k++) begin
      int idx;
      idx = (start + k) % 4;
      if (idx != skip && rq[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_g();
    return m_busy ? 4'(1 << m_owner) : 4'b0000;
  endfunction

  task automatic model_update(input logic r, input logic [3:0] rq, input logic sr);
    int w;
    if (r) begin
      m_busy = 0; m_owner = 0; m_ptr = 0; m_cnt = 0;
    end else if (!m_busy) begin
      w = pick(rq, m_ptr, -1);
      if (w >= 0) begin m_busy = 1; m_owner = w; m_cnt = 0; end
    end else if (!rq[m_owner]) begin
      m_ptr = (m_owner + 1) % 4;
      w = pick(rq, m_ptr, m_owner);
      if (w >= 0) begin m_owner = w; m_cnt = 0; end
      else m_busy = 0;
    end else if (MH != 0 && m_cnt >= MH && pick(rq, 0, m_owner) >= 0 && sr) begin
      m_ptr = (m_owner + 1) % 4;
      m_owner = pick(rq, m_ptr, m_owner);
      m_cnt = 0;
    end else begin
      m_cnt = (m_cnt + 1 > MH) ? MH : m_cnt + 1;
    end
  endtask

  task automatic step(input logic r, input logic [3:0] rq, input logic sr);
    reset = r;
    {m3_req, m2_req, m1_req, m0_req} = rq;
    s_ready = sr;
    model_update(r, rq, sr);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 4'($urandom), 1'b1);
      tests++;
      if (dut_g !== 4'b0000 || owner !== 2'd0 || bus_busy !== 1'b0) begin
        fails++;
        $display("FAIL reset: grnt=%b owner=%0d busy=%b, want 0000/0/0", dut_g, owner, bus_busy);
      end
    end
    step(1'b0, 4'b0000, 1'b0);
    step(1'b0, 4'b0000, 1'b0);
    step(1'b0, 4'b0100, 1'b0);
    tests++;
    if (dut_g !== 4'b0100 || owner !== 2'd2 || bus_busy !== 1'b1) begin
      fails++;
      $display("FAIL first_grant: grnt=%b owner=%0d busy=%b, want 0100/2/1", dut_g, owner, bus_busy);
    end
  endtask

  task automatic test_handover();
    step(1'b1, 4'b0000, 1'b0);
    step(1'b0, 4'b0001, 1'b0);
    step(1'b0, 4'b1011, 1'b0);
    step(1'b0, 4'b1011, 1'b0);
    tests++;
    if (dut_g !== 4'b0001) begin
      fails++;
      $display("FAIL handover_hold: grnt=%b, want 0001", dut_g);
    end
    step(1'b0, 4'b1010, 1'b0);
    tests++;
    if (dut_g !== 4'b0010 || owner !== 2'd1) begin
      fails++;
      $display("FAIL handover_m1: grnt=%b owner=%0d, want 0010/1", dut_g, owner);
    end
    step(1'b0, 4'b1000, 1'b0);
    tests++;
    if (dut_g !== 4'b1000 || owner !== 2'd3) begin
      fails++;
      $display("FAIL handover_m3: grnt=%b owner=%0d, want 1000/3", dut_g, owner);
    end
  endtask

  task automatic test_round_robin();
    int order[$];
    int hold;
    int expected[5] = '{0, 1, 2, 3, 0};
    logic [3:0] rq;
    int last;
    step(1'b1, 4'b0000, 1'b0);
    hold = 0;
    last = -1;
    for (int i = 0; i < 20; i++) begin
      rq = 4'hF;
      if (m_busy && hold == 2) rq[m_owner] = 1'b0;
      last = m_busy ? m_owner : -1;
      step(1'b0, rq, 1'b0);
      if (m_busy && m_owner != last) hold = 1; else hold++;
      if (bus_busy === 1'b1 && (order.size() == 0 || order[order.size()-1] != int'(owner)))
        order.push_back(int'(owner));
    end
    for (int k = 0; k < 5; k++) begin
      tests++;
      if (order.size() <= k) begin
        fails++;
        $display("FAIL rr_order[%0d]: no grant seen, want %0d", k, expected[k]);
      end else if (order[k] != expected[k]) begin
        fails++;
        $display("FAIL rr_order[%0d]: owner=%0d, want %0d", k, order[k], expected[k]);
      end
    end
  endtask

  task automatic test_preempt();
    int bad;
    step(1'b1, 4'b0000, 1'b0);
    step(1'b0, 4'b0001, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 4'b0001, 1'b0);
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 4'b0101, 1'b0);
      if (dut_g !== 4'b0001) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL preempt_wait: %0d cycles lost grant while s_ready=0, want 0", bad);
    end
    step(1'b0, 4'b0101, 1'b1);
    tests++;
    if (dut_g !== 4'b0100 || owner !== 2'd2) begin
      fails++;
      $display("FAIL preempt_switch: grnt=%b owner=%0d, want 0100/2", dut_g, owner);
    end
  endtask

  task automatic test_alone_no_preempt();
    int bad;
    step(1'b1, 4'b0000, 1'b1);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 4'b0010, 1'b1);
      if (dut_g !== 4'b0010 || owner !== 2'd1) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL alone_hold: %0d cycles without m1 grant, want 0", bad);
    end
  endtask

  task automatic test_reset_mid();
    step(1'b1, 4'b0000, 1'b0);
    step(1'b0, 4'b1000, 1'b0);
    step(1'b0, 4'b1000, 1'b0);
    tests++;
    if (dut_g !== 4'b1000) begin
      fails++;
      $display("FAIL rst_mid_own: grnt=%b, want 1000", dut_g);
    end
    step(1'b1, 4'b1010, 1'b0);
    tests++;
    if (dut_g !== 4'b0000 || bus_busy !== 1'b0 || owner !== 2'd0) begin
      fails++;
      $display("FAIL rst_mid_drop: grnt=%b busy=%b owner=%0d, want 0000/0/0", dut_g, bus_busy, owner);
    end
    step(1'b0, 4'b1010, 1'b0);
    tests++;
    if (dut_g !== 4'b0010 || owner !== 2'd1) begin
      fails++;
      $display("FAIL rst_mid_ptr: grnt=%b owner=%0d, want 0010/1", dut_g, owner);
    end
  endtask

  task automatic test_random();
    logic [3:0] rq;
    int bad_g, bad_o, bad_b;
    bad_g = 0; bad_o = 0; bad_b = 0;
    rq = 4'b0000;
    step(1'b1, rq, 1'b0);
    for (int i = 0; i < 600; i++) begin
      for (int m = 0; m < 4; m++) begin
        if (rq[m]) begin if ($urandom_range(5) == 0) rq[m] = 1'b0; end
        else if ($urandom_range(2) == 0) rq[m] = 1'b1;
      end
      step(($urandom_range(60) == 0), rq, 1'($urandom));
      if (dut_g !== exp_g()) begin
        bad_g++;
        if (bad_g <= 3) $display("FAIL rand_grnt cyc %0d: grnt=%b, want %b", i, dut_g, exp_g());
      end
      if (owner !== 2'(m_owner)) begin
        bad_o++;
        if (bad_o <= 3) $display("FAIL rand_owner cyc %0d: owner=%0d, want %0d", i, owner, m_owner);
      end
      if (bus_busy !== m_busy) begin
        bad_b++;
        if (bad_b <= 3) $display("FAIL rand_busy cyc %0d: busy=%b, want %b", i, bus_busy, m_busy);
      end
    end
    tests += 3;
    if (bad_g != 0) fails++;
    if (bad_o != 0) fails++;
    if (bad_b != 0) fails++;
  endtask

  initial begin
    reset = 1'b1;
    {m3_req, m2_req, m1_req, m0_req} = 4'b0000;
    s_ready = 1'b0;
    m_busy = 0; m_owner = 0; m_ptr = 0; m_cnt = 0;
    test_reset();
    test_handover();
    test_round_robin();
    test_preempt();
    test_alone_no_preempt();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
